// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer.
// master: the controller side. It drives sec_tick, load, load_min, load_sec,
//         start, stop and clear, and observes the timer state.
// slave:  the timer side. It drives min, sec, running, borrow_min, expired
//         and done.
interface countdown_timer_if;
   logic       sec_tick;
   logic       load;
   logic [5:0] load_min;
   logic [5:0] load_sec;
   logic       start;
   logic       stop;
   logic       clear;
   logic [5:0] min;
   logic [5:0] sec;
   logic       running;
   logic       borrow_min;
   logic       expired;
   logic       done;

   modport master (
      output sec_tick, load, load_min, load_sec, start, stop, clear,
      input  min, sec, running, borrow_min, expired, done
   );

   modport slave (
      input  sec_tick, load, load_min, load_sec, start, stop, clear,
      output min, sec, running, borrow_min, expired, done
   );
endinterface

// File: rtl/countdown_timer.sv
// Down-counting mm:ss timer.
// It loads a preset, counts down by one on each sec_tick while running, and
// borrows from the minutes when the seconds wrap.
// It pulses expired and then holds done when it reaches 00:00.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - countdown_timer_if.slave: the control inputs and the registered
//           status outputs
module countdown_timer #(
   parameter int unsigned MAX_MIN = 59,
   parameter int unsigned MAX_SEC = 59
) (
   input logic            clk,
   input logic            reset,
   countdown_timer_if.slave bus
);

   localparam int unsigned VW = 6;
   localparam logic [VW-1:0] MAX_MIN_V = VW'(MAX_MIN);
   localparam logic [VW-1:0] MAX_SEC_V = VW'(MAX_SEC);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [VW-1:0] min_q, min_d;
   logic [VW-1:0] sec_q, sec_d;
   logic [VW-1:0] ld_min_sat, ld_sec_sat;
   logic          borrow_q, borrow_d;
   logic          expired_q, expired_d;
   logic          running_q, running_d;
   logic          done_q, done_d;
   logic          nonzero;

   // Clamp the preset values to the largest legal minute and second.
   assign ld_min_sat = (bus.load_min > MAX_MIN_V) ? MAX_MIN_V : bus.load_min;
   assign ld_sec_sat = (bus.load_sec > MAX_SEC_V) ? MAX_SEC_V : bus.load_sec;
   assign nonzero    = (min_q != '0) || (sec_q != '0);

   // State register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         min_q     <= '0;
         sec_q     <= '0;
         borrow_q  <= 1'b0;
         expired_q <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         borrow_q  <= borrow_d;
         expired_q <= expired_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic. Priority is clear > load > stop > start > sec_tick.
   // A command that does not apply in the current state is ignored and does
   // not block the commands below it.
   always_comb begin
      state_d   = state_q;
      min_d     = min_q;
      sec_d     = sec_q;
      borrow_d  = 1'b0;
      expired_d = 1'b0;

      if (bus.clear) begin
         state_d = IDLE;
         min_d   = '0;
         sec_d   = '0;
      end else if (bus.load && (state_q != RUN)) begin
         min_d   = ld_min_sat;
         sec_d   = ld_sec_sat;
         state_d = ((ld_min_sat == '0) && (ld_sec_sat == '0)) ? IDLE : PAUSED;
      end else if (bus.stop && (state_q == RUN)) begin
         state_d = PAUSED;
      end else if (bus.start && ((state_q == IDLE) || (state_q == PAUSED)) && nonzero) begin
         // A tick in the same cycle as start is not counted.
         state_d = RUN;
      end else if (bus.sec_tick && (state_q == RUN)) begin
         if (sec_q != '0) begin
            sec_d = sec_q - VW'(1);
            // Only the step from 00:01 to 00:00 expires; it never borrows.
            if ((min_q == '0) && (sec_q == VW'(1))) begin
               state_d   = DONE;
               expired_d = 1'b1;
            end
         end else begin
            // RUN is never entered at 00:00, so min is non-zero here.
            sec_d    = MAX_SEC_V;
            min_d    = min_q - VW'(1);
            borrow_d = 1'b1;
         end
      end

      running_d = (state_d == RUN);
      done_d    = (state_d == DONE);
   end

   assign bus.min        = min_q;
   assign bus.sec        = sec_q;
   assign bus.running    = running_q;
   assign bus.borrow_min = borrow_q;
   assign bus.expired    = expired_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer.
// The reference model keeps the value as a total number of seconds and the
// mode as a small integer. It applies the command rules of the timer to that
// plain-arithmetic state.
module tb_countdown_timer;

   logic clk;
   logic reset;

   countdown_timer_if tif ();

   countdown_timer #(.MAX_MIN(59), .MAX_SEC(59)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   int errors = 0;
   int checks = 0;

   int m_mode;
   int m_t;
   bit m_borrow;
   bit m_exp;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".min"},     32'(tif.min),        32'(m_t / 60));
      check({tag, ".sec"},     32'(tif.sec),        32'(m_t % 60));
      check({tag, ".running"}, 32'(tif.running),    32'(m_mode == M_RUN));
      check({tag, ".done"},    32'(tif.done),       32'(m_mode == M_DONE));
      check({tag, ".borrow"},  32'(tif.borrow_min), 32'(m_borrow));
      check({tag, ".expired"}, 32'(tif.expired),    32'(m_exp));
   endtask

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_t      = 0;
      m_borrow = 1'b0;
      m_exp    = 1'b0;
   endtask

   // One clock edge of the reference model.
   task automatic model_step(input bit ld, input int lm, input int ls,
                             input bit st, input bit sp, input bit cl, input bit tk);
      m_borrow = 1'b0;
      m_exp    = 1'b0;
      if (cl) begin
         m_mode = M_IDLE;
         m_t    = 0;
      end else if (ld && m_mode != M_RUN) begin
         m_t    = ((lm > 59) ? 59 : lm) * 60 + ((ls > 59) ? 59 : ls);
         m_mode = (m_t == 0) ? M_IDLE : M_PAUSE;
      end else if (sp && m_mode == M_RUN) begin
         m_mode = M_PAUSE;
      end else if (st && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_t != 0) begin
         m_mode = M_RUN;
      end else if (tk && m_mode == M_RUN) begin
         if (m_t % 60 == 0) m_borrow = 1'b1;
         m_t = m_t - 1;
         if (m_t == 0) begin
            m_mode = M_DONE;
            m_exp  = 1'b1;
         end
      end
   endtask

   // Drives one cycle of inputs, lets the model step on the edge and checks
   // the outputs 1 time unit after the edge.
   task automatic cyc(input string tag, input bit ld, input int lm, input int ls,
                      input bit st, input bit sp, input bit cl, input bit tk);
      @(negedge clk);
      tif.load     = ld;
      tif.load_min = 6'(lm);
      tif.load_sec = 6'(ls);
      tif.start    = st;
      tif.stop     = sp;
      tif.clear    = cl;
      tif.sec_tick = tk;
      @(posedge clk);
      model_step(ld, lm, ls, st, sp, cl, tk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick(input string tag);
      cyc(tag, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic load(input string tag, input int lm, input int ls);
      cyc(tag, 1, lm, ls, 0, 0, 0, 0);
   endtask

   task automatic start(input string tag);
      cyc(tag, 0, 0, 0, 1, 0, 0, 0);
   endtask

   initial begin
      reset        = 1'b0;
      tif.load     = 1'b0;
      tif.load_min = '0;
      tif.load_sec = '0;
      tif.start    = 1'b0;
      tif.stop     = 1'b0;
      tif.clear    = 1'b0;
      tif.sec_tick = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("rst");
      @(negedge clk);
      reset = 1'b1;
      idle("post_rst");

      // 01:02 borrows on the third tick.
      load("ld0102", 1, 2);
      start("st0102");
      tick("t0101");
      tick("t0100");
      tick("t0059");
      idle("hold0059");

      // 00:02 runs to expiry, and DONE is sticky.
      cyc("clr", 0, 0, 0, 0, 0, 1, 0);
      load("ld0002", 0, 2);
      start("st0002");
      tick("t0001");
      tick("t0000");
      idle("done_hold");
      start("done_start");
      tick("done_tick");
      cyc("done_st_tk", 0, 0, 0, 1, 0, 0, 1);

      // Load saturation, then a zero load, then start at zero.
      load("ld_sat", 63, 60);
      load("ld_zero", 0, 0);
      start("st_zero");
      tick("tk_zero");

      // A tick coincident with stop, and a tick coincident with start.
      load("ld0030", 0, 30);
      start("st0030");
      cyc("stop_tk", 0, 0, 0, 0, 1, 0, 1);
      cyc("start_tk", 0, 0, 0, 1, 0, 0, 1);
      tick("t0029");

      // A load while running is ignored; clear beats load and tick.
      load("ld0500", 5, 0);
      start("st0500");
      load("ld_in_run", 3, 0);
      cyc("clr_ld_tk", 1, 3, 0, 0, 0, 1, 1);
      idle("after_clr");

      // An asynchronous reset in the middle of counting at 02:15.
      load("ld0215", 2, 15);
      start("st0215");
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b1;
      tick("rst_tk0");
      tick("rst_tk1");
      start("rst_start");

      // Randomized commands.
      for (int i = 0; i < 3000; i++) begin
         bit ld, st, sp, cl, tk;
         int lm, ls;
         ld = ($urandom_range(0, 9) == 0);
         st = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 11) == 0);
         cl = ($urandom_range(0, 49) == 0);
         tk = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 1) == 0) begin
            lm = int'($urandom_range(0, 1));
            ls = int'($urandom_range(0, 5));
         end else begin
            lm = int'($urandom_range(0, 63));
            ls = int'($urandom_range(0, 63));
         end
         cyc("rand", ld, lm, ls, st, sp, cl, tk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting mm:ss timer and the counterpart of the up-counting minute/second chain.
- Loads a preset, decrements once per one-second tick, and borrows from minutes when seconds wrap 00→59.
- Flags expiry when it reaches 00:00.
- Sits beside the clock counters, sharing the same one-second tick source; drives the display mux and alarm/buzzer logic.

Parameters:
- MAX_MIN, 59, largest loadable minute value; larger load values saturate to this.
- MAX_SEC, 59, largest second value; seconds reload to this on borrow.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sec_tick  in  1  single-cycle pulse, one per second
- load  in  1  load preset from load_min/load_sec
- load_min  in  6  preset minutes
- load_sec  in  6  preset seconds
- start  in  1  begin or resume counting
- stop  in  1  pause counting
- clear  in  1  synchronous return to IDLE with value 00:00
- min  out  6  current minutes
- sec  out  6  current seconds
- running  out  1  high while state is RUN
- borrow_min  out  1  one-cycle pulse when a minute is consumed (sec 00→59)
- expired  out  1  one-cycle pulse on the cycle the value reaches 00:00
- done  out  1  level, high while state is DONE

Behaviour:
- All outputs are registered. Every change appears on the clock edge after the qualifying input cycle.
- Reset (asynchronous, reset=0):
  - state=IDLE; min=0, sec=0.
  - running, borrow_min, expired and done all 0.
  - Release is synchronous to clk. Reset mid-count abandons the count; no expired pulse is generated.
- States: IDLE, RUN, PAUSED, DONE.
- Input priority per cycle: clear > load > stop > start > sec_tick.
- clear: any state → IDLE, min=sec=0, all pulses 0.
- load:
  - Accepted in IDLE, PAUSED and DONE; ignored in RUN.
  - Stores min=min(load_min, MAX_MIN) and sec=min(load_sec, MAX_SEC).
  - Next state: IDLE if the stored value is 00:00, otherwise PAUSED. DONE is exited on load.
- start:
  - In IDLE or PAUSED with a non-zero value → RUN.
  - With value 00:00 → ignored.
  - In RUN or DONE → no effect.
- stop: RUN → PAUSED; no effect in other states.
- sec_tick in RUN, evaluated against the current registered value:
  - sec>0: sec−1.
  - sec=0 and min>0: sec=MAX_SEC, min−1, borrow_min=1 for one cycle.
  - If the decremented value is 00:00: next state DONE, expired=1 for one cycle, running=0.
- sec_tick is ignored outside RUN. A tick coincident with start in PAUSED or IDLE is not counted; the first decrement occurs on the next tick.
- stop and sec_tick in the same cycle in RUN: stop wins, no decrement.
- Borrow and expiry never coincide: expiry requires sec to go 1→0 with min=0.
- DONE holds 00:00 with done=1 until clear, load or reset. start in DONE is ignored.
- borrow_min and expired are 0 on every cycle other than the one described above.
- Arithmetic: 6-bit unsigned. Values never underflow; a decrement at 00:00 cannot occur because RUN is never entered at 00:00.

Test Plan:
- Reset assert mid-RUN at 02:15 → min=0, sec=0, IDLE, running=0, done=0 asynchronously. After release, sec_tick does nothing.
- load 01:02, start, 3 ticks:
  - values 01:01, 01:00, 00:59.
  - borrow_min pulses exactly once, on the 3rd tick.
  - running=1 throughout.
- load 00:02, start, 2 ticks:
  - values 00:01, then 00:00 with expired=1 for one cycle and done=1 held.
  - a further start and ticks leave 00:00/DONE.
- load min=63, sec=60 → saturates to 59:59, PAUSED. load 00:00 → IDLE. start with 00:00 → remains IDLE.
- RUN at 00:30: stop with a coincident tick → PAUSED at 00:30. Then start with a coincident tick → RUN at 00:30, next tick → 00:29.
- RUN at 05:00 with clear, load=03:00 and a tick in the same cycle → IDLE, 00:00, all pulses 0. load attempted during RUN is ignored and the value is unchanged.
